alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the consecutive stable clock cycles required to accept a button level change.
REQ-002 The block SHALL have parameter WIDTH, default 8, the operand and result width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port btn_go, input, 1 bit: raw, unsynchronised push-button (the centre button).
REQ-006 The block SHALL have port data_in, input, WIDTH bits: the switch operand value.
REQ-007 The block SHALL have port op_sel, input, 4 bits: the switch operation selector.
REQ-008 The block SHALL have port alu_y, input, WIDTH bits: the combinational ALU result computed from a_reg, b_reg and op_reg.
REQ-009 The block SHALL have ports a_reg and b_reg, outputs, WIDTH bits each: the latched operands, which also drive the A and B LEDs.
REQ-010 The block SHALL have port op_reg, output, 4 bits: the latched operation.
REQ-011 The block SHALL have port y_reg, output, WIDTH bits: the latched result.
REQ-012 The block SHALL have port state, output, 2 bits: the current FSM state encoding.
REQ-013 The block SHALL have port exec_pulse, output, 1 bit: high for exactly one cycle while in EXEC.
REQ-014 The block SHALL have port y_valid, output, 1 bit: y_reg holds the result of the current A/B/op.

Function
REQ-015 btn_go SHALL pass through a two-flop synchroniser before any other use.
REQ-016 The debouncer SHALL accept a new level only after the synchronised input differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles; any intermediate mismatch restarts the count at 0.
REQ-017 An internal go pulse SHALL last exactly one cycle, on the cycle the accepted level changes 0->1; a held button SHALL produce no further pulses.
REQ-018 A press SHALL cause go DEBOUNCE_CYCLES+2 cycles after the first rising clk edge at which btn_go is sampled high.
REQ-019 FSM states SHALL be LOAD_A=00, LOAD_B=01, EXEC=10 and SHOW=11.
REQ-020 In LOAD_A, go SHALL load a_reg<=data_in and transition to LOAD_B; otherwise the FSM SHALL hold.
REQ-021 In LOAD_B, go SHALL load b_reg<=data_in and op_reg<=op_sel and transition to EXEC; otherwise the FSM SHALL hold.
REQ-022 EXEC SHALL last exactly one cycle with exec_pulse=1; at its closing edge y_reg<=alu_y, y_valid<=1 and the FSM SHALL transition to SHOW. go SHALL be ignored in EXEC.
REQ-023 In SHOW, go SHALL load a_reg<=data_in, clear y_valid, keep y_reg, b_reg and op_reg unchanged, and transition to LOAD_B (chained entry).
REQ-024 Operands SHALL be captured unmodified (no arithmetic in this block); data_in and op_sel changes outside a go cycle SHALL have no effect.
REQ-025 The result latency SHALL be 1 cycle from the LOAD_B go to exec_pulse, and y_valid SHALL rise 2 cycles after that go.

Reset
REQ-026 reset asserted SHALL immediately (without waiting for clk) force state=LOAD_A, a_reg=b_reg=y_reg=0, op_reg=0, y_valid=0, exec_pulse=0, synchroniser flops=0, accepted level=0 and debounce count=0.
REQ-027 Reset mid-operation (including in EXEC) SHALL discard all progress; no y_reg update SHALL occur on the reset edge.
REQ-028 A button held through reset release SHALL be treated as a new press: exactly one go after DEBOUNCE_CYCLES+2 cycles.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, then press/release with data_in=0x12, then press with data_in=0x34 and op_sel=0x1, ALU model add -> a_reg=0x12, b_reg=0x34, op_reg=1, exec_pulse for one cycle, y_reg=0x46, y_valid=1, state=11.
REQ-030 btn_go high for 3 cycles, then low -> no go; state stays 00 and a_reg stays 0x00.
REQ-031 btn_go held high for 50 cycles in LOAD_A -> exactly one transition to LOAD_B, with go exactly 6 cycles after first sample.
REQ-032 btn_go toggling every 2 cycles for 20 cycles (bounce), then stable high -> exactly one go.
REQ-033 In SHOW, press with data_in=0x46 -> a_reg=0x46, y_valid=0, y_reg keeps 0x46, state=01.
REQ-034 Assert reset asynchronously between clk edges during EXEC -> outputs clear before the next edge, state=00, and y_reg stays 0x00 after reset release.

Source files
------------

// File: rtl/alu_sequencer.sv
// Button-driven operand/operation sequencer for an external combinational ALU.
// A debounced centre button steps through LOAD_A -> LOAD_B -> EXEC -> SHOW.
module alu_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WIDTH           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_go,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       op_sel,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] b_reg,
    output logic [3:0]       op_reg,
    output logic [WIDTH-1:0] y_reg,
    output logic [1:0]       state,
    output logic             exec_pulse,
    output logic             y_valid
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLoadA = 2'b00,
        StLoadB = 2'b01,
        StExec  = 2'b10,
        StShow  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              level_prev_q;
    logic              go;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, y_q, y_d;
    logic [3:0]        op_q, op_d;
    logic              y_valid_q, y_valid_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign go = level_q & ~level_prev_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        unique case (state_q)
            StLoadA: begin
                if (go) begin
                    a_d     = data_in;
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                if (go) begin
                    b_d     = data_in;
                    op_d    = op_sel;
                    state_d = StExec;
                end
            end
            StExec: begin
                y_d       = alu_y;
                y_valid_d = 1'b1;
                state_d   = StShow;
            end
            StShow: begin
                // Chained entry: new A, keep previous B/op/result on display.
                if (go) begin
                    a_d       = data_in;
                    y_valid_d = 1'b0;
                    state_d   = StLoadB;
                end
            end
            default: state_d = StLoadA;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            state_q      <= StLoadA;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            y_q          <= '0;
            y_valid_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_go};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            y_q          <= y_d;
            y_valid_q    <= y_valid_d;
        end
    end

    assign a_reg      = a_q;
    assign b_reg      = b_q;
    assign op_reg     = op_q;
    assign y_reg      = y_q;
    assign y_valid    = y_valid_q;
    assign state      = state_q;
    assign exec_pulse = (state_q == StExec);

endmodule
